// File: rtl/pipe_reg_mem_wb_sf.sv
// ---------------------------------------------------------------------------
// pipe_reg_mem_wb_sf
//   MEM/WB pipeline register for the RISC-V core. It captures the ALU result,
//   the memory read data, rd and the write-back control bits, and presents
//   the selected write-back value. It supports stall, flush and valid
//   tracking, and keeps saturating retired and bubble counters for debug.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   stall_in, flush_in    hold contents / insert a bubble (flush wins)
//   valid_in              incoming instruction is valid
//   reg_write_in          incoming instruction writes rd
//   mem_to_reg_in         1 = write memory data, 0 = write ALU result
//   alu_result_in         ALU result from the MEM stage
//   data_memory_out_in    data memory read value
//   rd_in                 destination register index
//   *_out                 registered copies of the fields above
//   wb_data_out           selected write-back value, from registered fields
//   retired_count         valid instructions that have left the stage
//   bubble_count          bubbles that have left the stage
// ---------------------------------------------------------------------------
module pipe_reg_mem_wb_sf #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned RD_BITS   = 5,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  input  logic                 reg_write_in,
  input  logic                 mem_to_reg_in,
  input  logic [DATA_BITS-1:0] alu_result_in,
  input  logic [DATA_BITS-1:0] data_memory_out_in,
  input  logic [RD_BITS-1:0]   rd_in,
  output logic                 valid_out,
  output logic                 reg_write_out,
  output logic                 mem_to_reg_out,
  output logic [DATA_BITS-1:0] alu_result_out,
  output logic [DATA_BITS-1:0] data_memory_out_out,
  output logic [RD_BITS-1:0]   rd_out,
  output logic [DATA_BITS-1:0] wb_data_out,
  output logic [CNT_BITS-1:0]  retired_count,
  output logic [CNT_BITS-1:0]  bubble_count
);

  // The stage contents move on whenever a flush occurs or no stall is present.
  logic advance;
  assign advance = flush_in | ~stall_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out           <= 1'b0;
      reg_write_out       <= 1'b0;
      mem_to_reg_out      <= 1'b0;
      alu_result_out      <= '0;
      data_memory_out_out <= '0;
      rd_out              <= '0;
    end else if (flush_in) begin
      valid_out           <= 1'b0;
      reg_write_out       <= 1'b0;
      mem_to_reg_out      <= 1'b0;
      alu_result_out      <= '0;
      data_memory_out_out <= '0;
      rd_out              <= '0;
    end else if (!stall_in) begin
      valid_out           <= valid_in;
      // Writes to x0 are dropped here, so WB never has to check rd.
      reg_write_out       <= reg_write_in & valid_in & (rd_in != '0);
      mem_to_reg_out      <= mem_to_reg_in & valid_in;
      alu_result_out      <= alu_result_in;
      data_memory_out_out <= data_memory_out_in;
      rd_out              <= rd_in;
    end
  end

  // The pre-edge valid_out classifies what leaves the stage on an advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
      bubble_count  <= '0;
    end else if (advance) begin
      if (valid_out) begin
        if (retired_count != '1) retired_count <= retired_count + CNT_BITS'(1);
      end else begin
        if (bubble_count != '1) bubble_count <= bubble_count + CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    wb_data_out = mem_to_reg_out ? data_memory_out_out : alu_result_out;
  end

endmodule
